bsg_timeslice_arbiter: RTL

- Shares one resource among els_p requesters using round-robin time slices.
- Each slice is timed by an internal dynamic-limit counter. The slice length is programmed at runtime through a config port.
- Sits between requesting engines and a shared bus/port that needs bounded hold times. It is the sequencing controller around a counter-with-limit datapath.

---
 rtl/bsg_timeslice_arb_pkg.sv | 20 ++
 rtl/bsg_timeslice_rr_pick.sv | 38 +++
 rtl/bsg_timeslice_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/bsg_timeslice_arb_pkg.sv
// Shared types and helpers for the time-slice arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   Contents: FSM state constants, owner-id width helper.
package bsg_timeslice_arb_pkg;

    // Width of an index into n elements, never less than one bit.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Owner-id width for the default four-requester configuration.
    localparam int owner_id_width_lp = safe_clog2(4);

    typedef logic [1:0] state_t;
    localparam state_t STATE_IDLE  = 2'd0;
    localparam state_t STATE_GRANT = 2'd1;
    localparam state_t STATE_GAP   = 2'd2;

endpackage

// File: rtl/bsg_timeslice_rr_pick.sv
// Rotating priority encoder: first request after the last owner, wrapping.
// Latency: combinational.
// Backpressure: none; the pick is only advisory until the caller registers it.
//   Ports: reqs (request vector), last (previous owner index),
//          pick_oh (one-hot pick), pick_id (pick index), pick_v (any request).
module bsg_timeslice_rr_pick
    import bsg_timeslice_arb_pkg::*;
#(
    parameter int els_p      = 4,
    parameter int id_width_p = owner_id_width_lp
)
(
    input  logic [els_p-1:0]      reqs,
    input  logic [id_width_p-1:0] last,
    output logic [els_p-1:0]      pick_oh,
    output logic [id_width_p-1:0] pick_id,
    output logic                  pick_v
);

    // The last owner is visited last (i == els_p), so it only wins when
    // nobody else is asking.
    always_comb begin
        int c;
        pick_oh = '0;
        pick_id = '0;
        pick_v  = 1'b0;
        c       = 0;
        for (int i = 1; i <= els_p; i++) begin
            c = (int'(last) + i) % els_p;
            if (!pick_v && reqs[c]) begin
                pick_v     = 1'b1;
                pick_id    = id_width_p'(c);
                pick_oh[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bsg_timeslice_arbiter.sv
// Round-robin time-slice arbiter; each slice lasts up to limit+1 cycles.
// Latency: one cycle from request to registered grant.
// Backpressure: owner keeps the grant while it requests, until its slice expires.
//   Ports: clk_i, reset_n_i (async active-low), reqs_i, cfg_v_i/cfg_limit_i
//          (limit load), grants_o, owner_id_o, count_o, slice_done_o, limit_o.
//   Option: define BSG_TIMESLICE_ARB_GAP_EN to insert a one-cycle idle gap
//           whenever ownership moves to a different requester.
module bsg_timeslice_arbiter
    import bsg_timeslice_arb_pkg::*;
#(
    parameter int els_p         = 4,
    parameter int width_p       = 16,
    parameter int reset_limit_p = 3
)
(
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [els_p-1:0]              reqs_i,
    input  logic                          cfg_v_i,
    input  logic [width_p-1:0]            cfg_limit_i,
    output logic [els_p-1:0]              grants_o,
    output logic [safe_clog2(els_p)-1:0]  owner_id_o,
    output logic [width_p-1:0]            count_o,
    output logic                          slice_done_o,
    output logic [width_p-1:0]            limit_o
);

    localparam int id_width_lp = safe_clog2(els_p);

    state_t                 state_r, state_n;
    logic [els_p-1:0]       grants_r, grants_n;
    logic [id_width_lp-1:0] owner_r, owner_n;
    logic [width_p-1:0]     count_r, count_n;
    logic [width_p-1:0]     shadow_r, shadow_n;
    logic [width_p-1:0]     limit_r;

    logic [els_p-1:0]       pick_oh;
    logic [id_width_lp-1:0] pick_id;
    logic                   pick_v;

    logic owner_req, at_limit, in_grant, slice_end, start;

    bsg_timeslice_rr_pick #(
        .els_p      (els_p),
        .id_width_p (id_width_lp)
    ) pick (
        .reqs    (reqs_i),
        .last    (owner_r),
        .pick_oh (pick_oh),
        .pick_id (pick_id),
        .pick_v  (pick_v)
    );

    assign owner_req    = reqs_i[owner_r];
    assign at_limit     = (count_r == shadow_r);
    assign in_grant     = (state_r == STATE_GRANT);
    assign slice_end    = ~owner_req | at_limit;
    assign slice_done_o = in_grant & owner_req & at_limit;

    always_comb begin
        state_n  = state_r;
        grants_n = grants_r;
        owner_n  = owner_r;
        count_n  = count_r;
        shadow_n = shadow_r;
        start    = 1'b0;
        case (state_r)
            STATE_IDLE: start = pick_v;
            STATE_GRANT: begin
                if (!slice_end) begin
                    // count stops at shadow because slice_end fires there
                    count_n = count_r + width_p'(1);
                end else if (pick_v) begin
`ifdef BSG_TIMESLICE_ARB_GAP_EN
                    if (pick_id != owner_r) begin
                        // bus turnaround; owner kept so the re-pick rotates from it
                        state_n  = STATE_GAP;
                        grants_n = '0;
                        count_n  = '0;
                    end else begin
                        start = 1'b1;
                    end
`else
                    start = 1'b1;
`endif
                end else begin
                    state_n  = STATE_IDLE;
                    grants_n = '0;
                    count_n  = '0;
                end
            end
`ifdef BSG_TIMESLICE_ARB_GAP_EN
            STATE_GAP: begin
                if (pick_v) start   = 1'b1;
                else        state_n = STATE_IDLE;
            end
`endif
            default: begin
                state_n  = STATE_IDLE;
                grants_n = '0;
                count_n  = '0;
            end
        endcase

        // Slice start: a config write on this same edge bypasses into shadow.
        if (start) begin
            state_n  = STATE_GRANT;
            grants_n = pick_oh;
            owner_n  = pick_id;
            count_n  = '0;
            shadow_n = cfg_v_i ? cfg_limit_i : limit_r;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= STATE_IDLE;
            grants_r <= '0;
            owner_r  <= id_width_lp'(els_p - 1);
            count_r  <= '0;
            shadow_r <= width_p'(reset_limit_p);
            limit_r  <= width_p'(reset_limit_p);
        end else begin
            state_r  <= state_n;
            grants_r <= grants_n;
            owner_r  <= owner_n;
            count_r  <= count_n;
            shadow_r <= shadow_n;
            if (cfg_v_i) limit_r <= cfg_limit_i;
        end
    end

    assign grants_o   = grants_r;
    assign owner_id_o = owner_r;
    assign count_o    = count_r;
    assign limit_o    = limit_r;

endmodule
